// File: rtl/crc_check.sv
// Streaming CRC checker: delays the frame by N words so the CRC trailer can be
// stripped, forwards the payload and emits one pass/fail/runt verdict per frame.
module crc_check #(
  parameter int unsigned          I_WIDTH = 8,
  parameter int unsigned          O_WIDTH = 32,
  parameter bit                   REFI    = 1'b1,
  parameter bit                   REFO    = 1'b1,
  parameter logic [O_WIDTH-1:0]   POLY    = 32'h04c1_1db7,
  parameter logic [O_WIDTH-1:0]   INIT    = 32'hffff_ffff,
  parameter logic [O_WIDTH-1:0]   XORO    = 32'hffff_ffff
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [I_WIDTH-1:0] in_data_i,
  input  logic               in_valid_i,
  input  logic               in_last_i,
  output logic [I_WIDTH-1:0] out_data_o,
  output logic               out_valid_o,
  output logic               out_last_o,
  output logic               chk_valid_o,
  output logic               chk_ok_o,
  output logic               chk_runt_o
);

  localparam int unsigned N  = O_WIDTH / I_WIDTH;
  localparam int unsigned CW = $clog2(N + 1);

  function automatic logic [I_WIDTH-1:0] reflect_word(input logic [I_WIDTH-1:0] d);
    logic [I_WIDTH-1:0] r;
    for (int i = 0; i < int'(I_WIDTH); i++) r[i] = d[int'(I_WIDTH)-1-i];
    return r;
  endfunction

  function automatic logic [O_WIDTH-1:0] reflect_crc(input logic [O_WIDTH-1:0] d);
    logic [O_WIDTH-1:0] r;
    for (int i = 0; i < int'(O_WIDTH); i++) r[i] = d[int'(O_WIDTH)-1-i];
    return r;
  endfunction

  // Bitwise LFSR, MSB of the (possibly reflected) word enters first.
  function automatic logic [O_WIDTH-1:0] crc_step(input logic [O_WIDTH-1:0] c_in,
                                                  input logic [I_WIDTH-1:0] d);
    logic [O_WIDTH-1:0] c;
    logic               fb;
    c = c_in;
    for (int b = int'(I_WIDTH) - 1; b >= 0; b--) begin
      fb = c[O_WIDTH-1] ^ d[b];
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  // line_reg[0] is the newest word, line_reg[N-1] the oldest.
  logic [N-1:0][I_WIDTH-1:0] line_reg;
  logic [CW-1:0]             cnt_reg;
  logic [O_WIDTH-1:0]        crc_reg;
  logic [I_WIDTH-1:0]        out_data_reg;
  logic                      out_valid_reg;
  logic                      out_last_reg;
  logic                      chk_valid_reg;
  logic                      chk_ok_reg;
  logic                      chk_runt_reg;

  logic                      full;
  logic                      runt;
  logic [I_WIDTH-1:0]        payload_word;
  logic [O_WIDTH-1:0]        crc_next;
  logic [O_WIDTH-1:0]        fcrc;
  logic [N-1:0][I_WIDTH-1:0] exp_trl;
  logic [N-1:0][I_WIDTH-1:0] rcv_trl;

  assign full         = (cnt_reg == CW'(N));
  assign runt         = (cnt_reg < CW'(N - 1));
  assign payload_word = REFI ? reflect_word(line_reg[N-1]) : line_reg[N-1];
  assign crc_next     = full ? crc_step(crc_reg, payload_word) : crc_reg;
  assign fcrc         = (REFO ? reflect_crc(crc_next) : crc_next) ^ XORO;

  // Trailer word gi in arrival order: expected from fcrc, received from the line.
  genvar gi;
  generate
    for (gi = 0; gi < int'(N); gi++) begin : g_trl
      if (REFO) begin : g_refo
        assign exp_trl[gi] = fcrc[gi*I_WIDTH +: I_WIDTH];
      end else begin : g_norefo
        assign exp_trl[gi] = fcrc[(int'(N)-1-gi)*I_WIDTH +: I_WIDTH];
      end
      if (gi < int'(N) - 1) begin : g_line
        assign rcv_trl[gi] = line_reg[int'(N)-2-gi];
      end else begin : g_in
        assign rcv_trl[gi] = in_data_i;
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (in_valid_i) begin
      line_reg[0] <= in_data_i;
      for (int i = 1; i < int'(N); i++) line_reg[i] <= line_reg[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_reg       <= '0;
      crc_reg       <= INIT;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      chk_valid_reg <= 1'b0;
      chk_ok_reg    <= 1'b0;
      chk_runt_reg  <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      chk_valid_reg <= 1'b0;
      chk_ok_reg    <= 1'b0;
      chk_runt_reg  <= 1'b0;
      if (in_valid_i) begin
        if (full) begin
          out_data_reg  <= line_reg[N-1];
          out_valid_reg <= 1'b1;
          out_last_reg  <= in_last_i;
        end
        if (in_last_i) begin
          cnt_reg       <= '0;
          crc_reg       <= INIT;
          chk_valid_reg <= 1'b1;
          chk_runt_reg  <= runt;
          chk_ok_reg    <= !runt && (exp_trl == rcv_trl);
        end else begin
          crc_reg <= crc_next;
          if (!full) cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign out_data_o  = out_data_reg;
  assign out_valid_o = out_valid_reg;
  assign out_last_o  = out_last_reg;
  assign chk_valid_o = chk_valid_reg;
  assign chk_ok_o    = chk_ok_reg;
  assign chk_runt_o  = chk_runt_reg;

endmodule

// File: doc/crc_check.md
# crc_check

Streaming CRC checker, the receive-side counterpart of the `crc` generator. It accepts a frame of `I_WIDTH`-bit words whose final `O_WIDTH/I_WIDTH` words carry the CRC. It strips that trailer and forwards the payload, then reports one pass/fail/runt verdict per frame. It sits at a link receiver, after deframing and before payload consumers. It uses the same CRC parameter set as `crc`, so one parameter set configures both ends.

## Interface
- `REFI`, 1: reflect each input word before CRC update.
- `REFO`, 1: reflect the final CRC register before `XORO`; also selects trailer word order.
- `POLY`, 32'h04c1_1db7: generator polynomial, implicit top bit omitted.
- `INIT`, 32'hffff_ffff: CRC register start value at each frame start.
- `XORO`, 32'hffff_ffff: final XOR value.
- `I_WIDTH`, 8: input word width. `O_WIDTH` must be an integer multiple of `I_WIDTH`.
- `O_WIDTH`, 32: CRC width. N = `O_WIDTH/I_WIDTH` is the number of trailer words.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `in_data_i`  in  `I_WIDTH`  frame word.
- `in_valid_i`  in  1  word qualifier. Gaps between valid beats are allowed. There is no backpressure.
- `in_last_i`  in  1  marks the last word of the frame (the last trailer word). Only meaningful when `in_valid_i` is high.
- `out_data_o`  out  `I_WIDTH`  payload word.
- `out_valid_o`  out  1  payload qualifier.
- `out_last_o`  out  1  marks the last payload word.
- `chk_valid_o`  out  1  one-cycle verdict strobe.
- `chk_ok_o`  out  1  CRC match. Valid only while `chk_valid_o` is high.
- `chk_runt_o`  out  1  the frame had fewer than N words. Valid only while `chk_valid_o` is high.

## Operation
- **Delay line.** An N-word shift register and a fill counter `cnt` (0..N) hold the newest words of the current frame.
- **Accepted beat, `cnt < N`.** The word is pushed into the line and `cnt` increments. Nothing is emitted.
- **Accepted beat, `cnt == N`.**
  - The oldest word leaves the line as payload and is emitted on `out_data_o`.
  - The CRC register is updated with that word, reflected first if `REFI`.
  - The incoming word is pushed into the line.
- **Trailer order.** Trailer word k (k = 0..N-1, in arrival order) is `fcrc[k*I_WIDTH +: I_WIDTH]` if `REFO`, else `fcrc[(N-1-k)*I_WIDTH +: I_WIDTH]`. `fcrc` = (`REFO` ? reflect(crc) : crc) ^ `XORO`.
- **Beat with `in_last_i` high.**
  - The payload update from the rules above (if `cnt == N`) is applied first.
  - `fcrc` is formed from the updated register.
  - The N-word trailer (the N-1 newest line words plus the incoming word) is compared against `fcrc`.
- **Verdict.**
  - If the frame had fewer than N words in total: `chk_runt_o=1`, `chk_ok_o=0`.
  - Otherwise: `chk_runt_o=0`, and `chk_ok_o` is high exactly on a match.
- **Frame end.** After the `in_last_i` beat, `cnt` clears to 0 and the CRC register loads `INIT`. The next valid beat starts a new frame with no idle cycle required.
- **Zero payload.** A frame of exactly N words has no payload. No `out_valid_o` beat is produced. It is checked against `fcrc` of the empty message.
- **Simultaneous events.** The verdict of frame A and the first beat of frame B may share a cycle. They are independent and no state is shared.
- **Width rule.** CRC arithmetic is a bitwise LFSR over `I_WIDTH` bits per beat, MSB-first after optional reflection. It matches `crc` bit-exactly.

## Timing
- All outputs are registered.
- **Reset** (`rst_n_i` low at a clock edge) forces:
  - all outputs to 0;
  - `cnt` to 0;
  - the CRC register to `INIT`.
- **Reset mid-frame** discards the partial frame. No verdict and no `out_last_o` are produced for it.
- **Payload latency.** A word is emitted 1 cycle after the beat that pushes it out of the line. `out_valid_o` is high for exactly that cycle.
- **Last payload word.** `out_last_o` is high together with the payload word emitted on the `in_last_i` beat. If the payload is empty, `out_last_o` is never asserted.
- **Verdict latency.** `chk_valid_o` pulses for 1 cycle, exactly 1 cycle after the `in_last_i` beat, in the same cycle as `out_last_o` when a payload exists.
- **Invalid cycles.** Cycles with `in_valid_i` low change no state, and no output is asserted for them.

## Test plan
- **Good frame.** CRC-32 defaults: payload ASCII "123456789", then trailer 26 39 F4 CB, `in_last_i` on CB. Required: 9 `out_valid_o` beats 31..39, `out_last_o` on 39, `chk_valid_o=1` and `chk_ok_o=1` in that same cycle, `chk_runt_o=0`.
- **Corrupted frame.** Same frame with payload byte '5' changed to 0x34. Required: the same payload stream as received, `chk_ok_o=0`, `chk_runt_o=0`.
- **Empty payload.** Frame 00 00 00 00 (the CRC of an empty message is 0x00000000). Required: no `out_valid_o` beats, `chk_ok_o=1`.
- **Runt frame.** 3-word frame AA BB CC, `in_last_i` on CC. Required: no payload, `chk_valid_o=1`, `chk_runt_o=1`, `chk_ok_o=0`.
- **Back-to-back with gaps.** The good frame followed immediately by the good frame again, with random `in_valid_i` gaps inside each frame. Required: two verdicts with `chk_ok_o=1`, payload identical each time, no beats merged across the frame boundary.
- **Reset mid-frame.** Assert `rst_n_i` low after 6 bytes of a frame, then send the good frame. Required: all outputs 0 the cycle after reset, no verdict for the aborted frame, `chk_ok_o=1` for the following frame.
